hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl.sv | 107 ++++++++++
 tb/tb_hilo_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register file with multiply-sequencing FSM and MTHI/MTLO write port
//
// Optional feature: define HILO_TIMEOUT_EN to abort a multiply that stays in
// WAIT for TIMEOUT cycles without mult_done (sets sticky timeout_err).
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   start        launch a multiply (accepted in IDLE only)
//   mthi_we      write wdata to HI (applied in IDLE only)
//   mtlo_we      write wdata to LO (applied in IDLE only)
//   wdata        register write data
//   mult_init    launch/hold to multiplier (LAUNCH, WAIT)
//   mult_done    multiplier result valid (looked at in WAIT only)
//   mult_hi/lo   multiplier product halves
//   hi_out/lo_out HI/LO register contents
//   busy         operation in flight
//   done         one-cycle pulse when HI/LO take the product
//   wr_conflict  sticky: MTHI/MTLO attempted while busy
//   timeout_err  sticky: multiplier did not finish in time
module hilo_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             mult_init,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             wr_conflict,
  output logic             timeout_err
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, WRITE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic r_conflict;
  logic w_timeout;
  logic w_accept;
  assign w_accept = (r_state == IDLE) && start;
`ifdef HILO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic r_timeout_err;
  // counter sits at zero outside WAIT, so every WAIT entry starts from zero
  always_ff @(posedge clk) begin
    if (reset || r_state != WAIT) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
  // r_cnt holds completed WAIT cycles; this fires on the TIMEOUT-th one
  assign w_timeout = (r_state == WAIT) && !mult_done && (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (reset) r_timeout_err <= 1'b0;
    else if (w_accept) r_timeout_err <= 1'b0;
    else if (w_timeout) r_timeout_err <= 1'b1;
  end
  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next    = r_state;
    mult_init = (r_state == LAUNCH) || (r_state == WAIT);
    busy      = r_state != IDLE;
    done      = r_state == WRITE;
    unique case (r_state)
      IDLE:    w_next = start ? LAUNCH : IDLE;
      LAUNCH:  w_next = WAIT;
      WAIT:    w_next = mult_done ? WRITE : (w_timeout ? IDLE : WAIT);
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // product lands on the WAIT->WRITE edge so it is visible alongside done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (r_state == WAIT && mult_done) begin
        r_hi <= mult_hi;
        r_lo <= mult_lo;
      end else if (r_state == IDLE) begin
        if (mthi_we) r_hi <= wdata;
        if (mtlo_we) r_lo <= wdata;
      end
      if (r_state != IDLE && (mthi_we || mtlo_we)) r_conflict <= 1'b1;
    end
  end
  assign hi_out      = r_hi;
  assign lo_out      = r_lo;
  assign wr_conflict = r_conflict;
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed plus randomized check of hilo_ctrl against a transaction-level model
module tb_hilo_ctrl;
  localparam int W  = 32;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, mthi_we = 1'b0, mtlo_we = 1'b0, mult_done = 1'b0;
  logic [W-1:0] wdata = '0, mult_hi = '0, mult_lo = '0;
  logic mult_init, busy, done, wr_conflict, timeout_err;
  logic [W-1:0] hi_out, lo_out;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  hilo_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .wdata(wdata), .mult_init(mult_init), .mult_done(mult_done), .mult_hi(mult_hi),
    .mult_lo(mult_lo), .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .wr_conflict(wr_conflict), .timeout_err(timeout_err)
  );
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: an operation is "in flight" from acceptance until its result cycle
  // finishes; age counts cycles since acceptance (1 = launch cycle, 2+ waiting).
  bit m_valid = 0;
  bit m_op, m_fin, m_conf, m_to;
  int m_age;
  logic [W-1:0] m_hi, m_lo;
  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_op = 0; m_fin = 0; m_conf = 0; m_to = 0; m_age = 0; m_hi = '0; m_lo = '0;
    end else if (!m_op) begin
      if (mthi_we) m_hi = wdata;
      if (mtlo_we) m_lo = wdata;
      if (start) begin m_op = 1; m_age = 1; m_to = 0; end
    end else begin
      if (mthi_we || mtlo_we) m_conf = 1;
      if (m_fin) begin
        m_op = 0; m_fin = 0;
      end else if (m_age >= 2 && mult_done) begin
        m_hi = mult_hi; m_lo = mult_lo; m_fin = 1;
      end else begin
`ifdef HILO_TIMEOUT_EN
        if (m_age - 1 == TO) begin m_op = 0; m_to = 1; end
`endif
        m_age++;
      end
    end
  end
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", W'(busy), W'(m_op));
      chk("done", W'(done), W'(m_fin));
      chk("mult_init", W'(mult_init), W'(m_op && !m_fin));
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
      chk("wr_conflict", W'(wr_conflict), W'(m_conf));
      chk("timeout_err", W'(timeout_err), W'(m_to));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    start = 0; mthi_we = 0; mtlo_we = 0; mult_done = 0; reset = 0;
  endtask
  initial begin
    idle_in(); reset = 1;
    step(); step();
    reset = 0;
    chk("rst_busy", W'(busy), 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_init", W'(mult_init), 0);
    // 7 * -3 product
    start = 1; step();
    start = 0; chk("launch_init", W'(mult_init), 1); step();
    mult_done = 1; mult_hi = 32'hFFFFFFFF; mult_lo = 32'hFFFFFFEB; step();
    mult_done = 0;
    chk("mul_done", W'(done), 1);
    chk("mul_hi", hi_out, 32'hFFFFFFFF);
    chk("mul_lo", lo_out, 32'hFFFFFFEB);
    step();
    chk("mul_busy_low", W'(busy), 0);
    chk("mul_done_once", W'(done), 0);
    // MTHI then MTLO, then both together
    mthi_we = 1; wdata = 32'h12345678; step();
    mthi_we = 0; mtlo_we = 1; wdata = 32'h9ABCDEF0; step();
    mtlo_we = 0;
    chk("mthi", hi_out, 32'h12345678);
    chk("mtlo", lo_out, 32'h9ABCDEF0);
    mthi_we = 1; mtlo_we = 1; wdata = 32'hA5A5A5A5; step();
    idle_in();
    chk("both_hi", hi_out, 32'hA5A5A5A5);
    chk("both_lo", lo_out, 32'hA5A5A5A5);
    // start with a same-cycle write: write lands, later result overwrites
    start = 1; mthi_we = 1; wdata = 32'h11111111; step();
    idle_in();
    chk("sw_hi", hi_out, 32'h11111111);
    chk("sw_busy", W'(busy), 1);
    step();
    mult_done = 1; mult_hi = 32'h22222222; mult_lo = 32'h33333333; step();
    idle_in();
    chk("sw_over", hi_out, 32'h22222222);
    // back-to-back: start on the IDLE cycle right after the result cycle
    step();
    start = 1; step();
    idle_in();
    chk("b2b_busy", W'(busy), 1);
    step();
    // reset in WAIT aborts and clears
    reset = 1; step();
    reset = 0;
    chk("rw_busy", W'(busy), 0);
    chk("rw_init", W'(mult_init), 0);
    chk("rw_done", W'(done), 0);
    chk("rw_hi", hi_out, 0);
    chk("rw_lo", lo_out, 0);
    // write while busy is dropped and flags a sticky conflict
    mtlo_we = 1; wdata = 32'h0000BEEF; step();
    mtlo_we = 0; start = 1; step();
    start = 0; mtlo_we = 1; wdata = 32'hDEADBEEF; step();
    mtlo_we = 0;
    chk("cf_lo", lo_out, 32'h0000BEEF);
    chk("cf_flag", W'(wr_conflict), 1);
    mult_done = 1; step();
    mult_done = 0; step(); step(); step();
    chk("cf_sticky", W'(wr_conflict), 1);
    reset = 1; step();
    reset = 0;
    chk("cf_clear", W'(wr_conflict), 0);
    // long wait: aborts after TO wait cycles if enabled, otherwise keeps waiting
    mthi_we = 1; wdata = 32'h0BADF00D; step();
    mthi_we = 0; start = 1; step();
    start = 0;
    repeat (TO) step();
    chk("to_still_busy", W'(busy), 1);
    step();
`ifdef HILO_TIMEOUT_EN
    chk("to_busy", W'(busy), 0);
    chk("to_err", W'(timeout_err), 1);
    chk("to_hi", hi_out, 32'h0BADF00D);
    start = 1; step();
    start = 0;
    chk("to_clear", W'(timeout_err), 0);
    step();
    mult_done = 1; step();
    mult_done = 0; step();
`else
    chk("nto_busy", W'(busy), 1);
    chk("nto_err", W'(timeout_err), 0);
    mult_done = 1; step();
    mult_done = 0; step();
`endif
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(63) == 0);
      start     = ($urandom_range(2) == 0);
      mthi_we   = ($urandom_range(7) == 0);
      mtlo_we   = ($urandom_range(7) == 0);
      mult_done = ($urandom_range(3) == 0) || (i % 500 > 440 ? 1'b0 : 1'b0);
      wdata     = $urandom;
      mult_hi   = $urandom;
      mult_lo   = $urandom;
      if (i % 700 > 600) mult_done = 0;
      step();
    end
    idle_in();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
